// File: rtl/ref_clk_sel_encoder_pkg.sv
// Shared constants, FSM state type and one-hot helpers for the ref-clock select readback path.
package ref_clk_pkg;

  localparam int TGATE_W       = 5;
  localparam int REF_CLK_SEL_W = 3;

  localparam logic [REF_CLK_SEL_W-1:0] REF_CLK_SEL_DEFAULT = 3'd1;
  localparam logic [TGATE_W-1:0]       TGATE_DEFAULT       = 5'b00010;

  typedef enum logic {
    SETTLE = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Maps a one-hot tgate vector to its divider select; non-one-hot input returns the default.
  function automatic logic [REF_CLK_SEL_W-1:0] onehot_enc(input logic [TGATE_W-1:0] v);
    logic [REF_CLK_SEL_W-1:0] code;
    case (v)
      5'b00001: code = 3'd0;
      5'b00010: code = 3'd1;
      5'b00100: code = 3'd2;
      5'b01000: code = 3'd3;
      5'b10000: code = 3'd4;
      default:  code = REF_CLK_SEL_DEFAULT;
    endcase
    return code;
  endfunction

  function automatic logic is_onehot(input logic [TGATE_W-1:0] v);
    return (v != 5'b00000) && ((v & (v - 5'b00001)) == 5'b00000);
  endfunction

endpackage

// File: rtl/ref_clk_sync2.sv
// Per-bit multi-stage synchronizer with a loadable reset value, for quasi-static async status.
module ref_clk_sync2 #(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] rst_val,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_r [STAGES];

  // Shift chain; every stage loads rst_val on synchronous reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_r[i] <= rst_val;
      end
    end else begin
      stage_r[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  assign q = stage_r[STAGES-1];

endmodule

// File: rtl/ref_clk_sel_encoder.sv
// Synchronizes, debounces and one-hot checks the divider tgate status, and encodes it
// back to the ref_clk_sel code with valid/error/change flags for slow-control readout.
module ref_clk_sel_encoder
  import ref_clk_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [TGATE_W-1:0]       tgate_status,
  input  logic                     clr_err,
  output logic [REF_CLK_SEL_W-1:0] sel_code,
  output logic                     sel_valid,
  output logic                     onehot_err,
  output logic                     err_sticky,
  output logic                     change_pulse
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  logic [TGATE_W-1:0]       stat_s;
  logic [TGATE_W-1:0]       prev_r;
  logic                     chg_s;
  state_t                   state_r, state_nxt;
  logic [CNT_W-1:0]         cnt_r, cnt_nxt;
  logic [REF_CLK_SEL_W-1:0] sel_code_r, sel_code_nxt;
  logic [REF_CLK_SEL_W-1:0] last_code_r, last_code_nxt;
  logic                     sel_valid_r, sel_valid_nxt;
  logic                     onehot_err_r, onehot_err_nxt;
  logic                     err_sticky_r, err_sticky_nxt;
  logic                     change_pulse_r, change_pulse_nxt;
  logic [REF_CLK_SEL_W-1:0] enc_s;

  ref_clk_sync2 #(
    .WIDTH  (TGATE_W),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rstn    (rstn),
    .rst_val (TGATE_DEFAULT),
    .d       (tgate_status),
    .q       (stat_s)
  );

  assign chg_s = (stat_s != prev_r);
  assign enc_s = onehot_enc(stat_s);

  // Next-state and output decode; any change restarts the settle window.
  always_comb begin
    state_nxt        = state_r;
    cnt_nxt          = cnt_r;
    sel_code_nxt     = sel_code_r;
    last_code_nxt    = last_code_r;
    sel_valid_nxt    = sel_valid_r;
    onehot_err_nxt   = onehot_err_r;
    err_sticky_nxt   = err_sticky_r & ~clr_err;
    change_pulse_nxt = 1'b0;
    if (chg_s) begin
      state_nxt     = SETTLE;
      cnt_nxt       = CNT_ZERO;
      sel_valid_nxt = 1'b0;
    end else begin
      case (state_r)
        SETTLE: begin
          if (cnt_r < CNT_LAST) begin
            cnt_nxt = cnt_r + CNT_ONE;
          end else begin
            state_nxt = LOCKED;
            if (is_onehot(stat_s)) begin
              sel_code_nxt     = enc_s;
              last_code_nxt    = enc_s;
              sel_valid_nxt    = 1'b1;
              onehot_err_nxt   = 1'b0;
              change_pulse_nxt = (enc_s != last_code_r);
            end else begin
              // Error set overrides a coincident clr_err.
              sel_valid_nxt  = 1'b0;
              onehot_err_nxt = 1'b1;
              err_sticky_nxt = 1'b1;
            end
          end
        end
        LOCKED:  state_nxt = LOCKED;
        default: state_nxt = SETTLE;
      endcase
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r        <= SETTLE;
      cnt_r          <= CNT_ZERO;
      prev_r         <= TGATE_DEFAULT;
      sel_code_r     <= REF_CLK_SEL_DEFAULT;
      last_code_r    <= REF_CLK_SEL_DEFAULT;
      sel_valid_r    <= 1'b0;
      onehot_err_r   <= 1'b0;
      err_sticky_r   <= 1'b0;
      change_pulse_r <= 1'b0;
    end else begin
      state_r        <= state_nxt;
      cnt_r          <= cnt_nxt;
      prev_r         <= stat_s;
      sel_code_r     <= sel_code_nxt;
      last_code_r    <= last_code_nxt;
      sel_valid_r    <= sel_valid_nxt;
      onehot_err_r   <= onehot_err_nxt;
      err_sticky_r   <= err_sticky_nxt;
      change_pulse_r <= change_pulse_nxt;
    end
  end

  assign sel_code     = sel_code_r;
  assign sel_valid    = sel_valid_r;
  assign onehot_err   = onehot_err_r;
  assign err_sticky   = err_sticky_r;
  assign change_pulse = change_pulse_r;

endmodule
